// File: rtl/eoc_data_receiver.sv
// EOC data receiver: grants the congestion arbiter, stamps accepted words with a free-running
// TimeStamp and buffers them in a first-word fall-through FIFO. Optional stats: RX_STATS_EN.
`timescale 1ns/1ps

module eoc_data_receiver #(
    parameter int DEPTH = 4
) (
    input  logic        clk_40MHz,
    input  logic        rst_n,
    input  logic [26:0] data_eoc_arbiter,
    output logic        shake_hands_col,
    output logic [8:0]  TimeStamp,
    output logic [35:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready
`ifdef RX_STATS_EN
    ,
    output logic [15:0] word_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [35:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [8:0]    r_ts;
    logic          r_shake;

    logic          w_push;
    logic          w_pop;
    logic          w_valid;
    logic [CW-1:0] w_count_next;

    // A tag bit alone is not data; only a non-zero payload is accepted.
    assign w_push  = r_shake && (data_eoc_arbiter[26:1] != 26'd0);
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && dout_ready;

    always_comb begin
        // NOTE: default first so every path assigns it; otherwise a latch is inferred.
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // NOTE: storage is deliberately left out of reset; the count guards every read of it.
    always_ff @(posedge clk_40MHz) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_ts, data_eoc_arbiter};
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ts     <= '0;
            r_shake  <= 1'b0;
        end else begin
            r_ts    <= r_ts + 9'd1;
            r_count <= w_count_next;
            r_shake <= (w_count_next != FULL_CNT);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

`ifdef RX_STATS_EN
    logic [15:0] r_word_count;

    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_word_count <= '0;
        end else if (w_push && (r_word_count != 16'hFFFF)) begin
            r_word_count <= r_word_count + 16'd1;
        end
    end

    assign word_count = r_word_count;
`endif

    assign shake_hands_col = r_shake;
    assign TimeStamp       = r_ts;
    assign dout_valid      = w_valid;
    assign dout            = w_valid ? r_mem[r_rd_ptr] : '0;

endmodule
